// File: rtl/pattern_generator_if.sv
// Request/status bundle between a pattern requester and the serial pattern generator.
interface pattern_generator_if #(
  parameter int unsigned PAT_W = 6,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned GAP_W = 4
);
  logic             start;
  logic [PAT_W-1:0] pat_in;
  logic [CNT_W-1:0] rep_cnt;
  logic [GAP_W-1:0] gap_len;
  logic             abort;
  logic             out;
  logic             out_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, pat_in, rep_cnt, gap_len, abort,
    input  out, out_valid, busy, done
  );

  modport slave (
    input  start, pat_in, rep_cnt, gap_len, abort,
    output out, out_valid, busy, done
  );
endinterface

// File: rtl/pattern_generator.sv
// Serial MSB-first pattern transmitter with programmable repeat count and inter-pattern gap.
module pattern_generator #(
  parameter int unsigned PAT_W = 6,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned GAP_W = 4
) (
  input logic                clk,
  input logic                rst,
  pattern_generator_if.slave bus
);

  localparam int unsigned IdxW = $clog2(PAT_W);
  localparam logic [IdxW-1:0] IdxMax = IdxW'(PAT_W - 1);

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gcnt_q, gcnt_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             out_q, out_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Outputs are computed one cycle ahead so every port is a plain flop.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    rep_d   = rep_q;
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;
    idx_d   = idx_q;
    out_d   = 1'b0;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!bus.abort && bus.start && (bus.rep_cnt != '0)) begin
          pat_d   = bus.pat_in;
          rep_d   = bus.rep_cnt;
          gap_d   = bus.gap_len;
          idx_d   = IdxMax;
          out_d   = bus.pat_in[PAT_W-1];
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = StShift;
        end
      end
      StShift: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else if (idx_q != '0) begin
          idx_d   = idx_q - 1'b1;
          out_d   = pat_q[idx_d];
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end else if (rep_q == CNT_W'(1)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          // rep_q counts repetitions still owed, including the one just finished.
          rep_d  = rep_q - 1'b1;
          busy_d = 1'b1;
          if (gap_q != '0) begin
            gcnt_d  = gap_q;
            state_d = StGap;
          end else begin
            idx_d   = IdxMax;
            out_d   = pat_q[PAT_W-1];
            valid_d = 1'b1;
          end
        end
      end
      StGap: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else if (gcnt_q == GAP_W'(1)) begin
          idx_d   = IdxMax;
          out_d   = pat_q[PAT_W-1];
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = StShift;
        end else begin
          gcnt_d = gcnt_q - 1'b1;
          busy_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pat_q   <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
      idx_q   <= '0;
      out_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_pattern_generator.sv
// Directed bench for pattern_generator; each check compares {out, out_valid, busy, done}.
module tb_pattern_generator;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  pattern_generator_if #(.PAT_W(6), .CNT_W(8), .GAP_W(4)) bus ();

  pattern_generator #(.PAT_W(6), .CNT_W(8), .GAP_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle; outputs are then those of the new cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {bus.out, bus.out_valid, bus.busy, bus.done};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed {out,valid,busy,done}=%b expected %b", tag, obs, exp);
    end
  endtask

  task automatic drive_start(input logic [5:0] pat, input logic [7:0] reps,
                             input logic [3:0] gap);
    bus.start   = 1'b1;
    bus.pat_in  = pat;
    bus.rep_cnt = reps;
    bus.gap_len = gap;
    tick();
    bus.start   = 1'b0;
  endtask

  // Called in cycle 1 of a transfer; returns in the cycle that carries done.
  task automatic expect_xfer(input string tag, input logic [5:0] pat, input int reps,
                             input int gap);
    for (int r = 0; r < reps; r++) begin
      for (int i = 5; i >= 0; i--) begin
        chk($sformatf("%s r%0d b%0d", tag, r, i), {pat[i], 3'b110});
        tick();
      end
      if (r < reps - 1) begin
        for (int g = 0; g < gap; g++) begin
          chk($sformatf("%s r%0d gap%0d", tag, r, g), 4'b0010);
          tick();
        end
      end
    end
    chk({tag, " done"}, 4'b0001);
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.pat_in  = '0;
    bus.rep_cnt = '0;
    bus.gap_len = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset", 4'b0000);

    // Single repetition, explicit cycle-by-cycle values.
    drive_start(6'b110101, 8'd1, 4'd0);
    chk("t1 c1", 4'b1110);
    tick(); chk("t1 c2", 4'b1110);
    tick(); chk("t1 c3", 4'b0110);
    tick(); chk("t1 c4", 4'b1110);
    tick(); chk("t1 c5", 4'b0110);
    tick(); chk("t1 c6", 4'b1110);
    tick(); chk("t1 c7 done", 4'b0001);
    tick(); chk("t1 c8 idle", 4'b0000);

    // Three repetitions with a two-cycle gap: done at cycle 23.
    drive_start(6'b110101, 8'd3, 4'd2);
    expect_xfer("t2", 6'b110101, 3, 2);
    tick(); chk("t2 after", 4'b0000);

    // Back-to-back repetitions.
    drive_start(6'b100001, 8'd2, 4'd0);
    expect_xfer("t3", 6'b100001, 2, 0);
    tick(); chk("t3 after", 4'b0000);

    // rep_cnt of zero is ignored.
    drive_start(6'b111111, 8'd0, 4'd1);
    for (int c = 1; c <= 10; c++) begin
      chk($sformatf("t4 zero c%0d", c), 4'b0000);
      tick();
    end

    // start while busy is neither applied nor queued.
    drive_start(6'b110101, 8'd1, 4'd0);
    chk("t5 c1", 4'b1110);
    tick(); chk("t5 c2", 4'b1110);
    tick(); chk("t5 c3", 4'b0110);
    bus.start   = 1'b1;
    bus.pat_in  = 6'b000000;
    bus.rep_cnt = 8'd5;
    tick(); bus.start = 1'b0;
    chk("t5 c4", 4'b1110);
    tick(); chk("t5 c5", 4'b0110);
    tick(); chk("t5 c6", 4'b1110);
    tick(); chk("t5 c7 done", 4'b0001);
    for (int c = 8; c <= 10; c++) begin
      tick(); chk($sformatf("t5 c%0d idle", c), 4'b0000);
    end

    // abort during cycle 4 of a two-repetition transfer.
    drive_start(6'b110101, 8'd2, 4'd0);
    chk("t6 c1", 4'b1110);
    tick(); chk("t6 c2", 4'b1110);
    tick(); chk("t6 c3", 4'b0110);
    tick(); chk("t6 c4", 4'b1110);
    bus.abort = 1'b1;
    tick(); bus.abort = 1'b0;
    chk("t6 c5 aborted", 4'b0000);
    tick(); chk("t6 c6 no done", 4'b0000);
    drive_start(6'b100001, 8'd1, 4'd0);
    expect_xfer("t6 restart", 6'b100001, 1, 0);
    tick(); chk("t6 after", 4'b0000);

    // abort together with start in IDLE: abort wins.
    bus.abort = 1'b1;
    drive_start(6'b111111, 8'd1, 4'd0);
    bus.abort = 1'b0;
    chk("t7 abort+start", 4'b0000);
    tick(); chk("t7 idle", 4'b0000);

    // rst in the middle of a gap.
    drive_start(6'b110101, 8'd2, 4'd3);
    for (int i = 5; i >= 0; i--) begin
      chk($sformatf("t8 b%0d", i), {i[0] ? 1'b0 : 1'b1, 3'b110} ^ {(i == 5), 3'b000});
      tick();
    end
    chk("t8 gap", 4'b0010);
    rst = 1'b1;
    tick(); rst = 1'b0;
    chk("t8 reset", 4'b0000);
    tick(); chk("t8 idle1", 4'b0000);
    tick(); chk("t8 idle2", 4'b0000);

    // start in the done cycle is accepted.
    drive_start(6'b101010, 8'd1, 4'd0);
    expect_xfer("t9a", 6'b101010, 1, 0);
    drive_start(6'b011110, 8'd1, 4'd0);
    expect_xfer("t9b", 6'b011110, 1, 0);
    tick(); chk("t9 after", 4'b0000);

    // Maximum repetition count must not wrap early.
    drive_start(6'b111001, 8'd255, 4'd0);
    expect_xfer("t10 max", 6'b111001, 255, 0);
    tick(); chk("t10 after", 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
